mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data-memory port, downstream of the core, beside DMEM.

---
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV window on the data port,
// byte FIFO feeding a start/data/stop serialiser.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | tx high; pops FIFO head and latches divider when not empty
// ST_START | start bit, tx low for div_q cycles
// ST_DATA  | 8 data bits LSB first, div_q cycles each
// ST_STOP  | stop bit, tx high for div_q cycles
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        tx_idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   baud_div;
    logic [15:0]   div_q;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [31:0]   offset;
    logic          sel_txdata, sel_status, sel_baud;
    logic          wr_txdata, wr_status, wr_baud;
    logic          full, empty, push, pop;
    logic [3:0]    count4;
    logic [31:0]   status_word;

    logic          unused_bits;
    assign unused_bits = &{1'b0, dwdata[31:16], dwe[3:1]};

    assign offset     = daddr - BASE_ADDR;
    assign hit        = (daddr >= BASE_ADDR) && (offset <= 32'd8) && (daddr[1:0] == 2'b00);
    assign sel_txdata = hit && (offset[3:2] == 2'd0);
    assign sel_status = hit && (offset[3:2] == 2'd1);
    assign sel_baud   = hit && (offset[3:2] == 2'd2);
    assign wr_txdata  = sel_txdata && dwe[0];
    assign wr_status  = sel_status && dwe[0];
    assign wr_baud    = sel_baud && dwe[0];

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_txdata && !full;
    assign pop     = (state == ST_IDLE) && !empty;
    assign tx_idle = empty && (state == ST_IDLE);

    assign count4      = 4'(count);
    assign status_word = {24'd0, count4, overflow, (state != ST_IDLE), empty, full};

    always_comb begin
        rdata = 32'd0;
        if (sel_status) rdata = status_word;
        else if (sel_baud) rdata = {16'd0, baud_div};
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dwdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a dropped push wins over a same-edge clear
            if (wr_txdata && full)
                overflow <= 1'b1;
            else if (wr_status && dwdata[3])
                overflow <= 1'b0;
            if (wr_baud)
                baud_div <= (dwdata[15:0] == 16'd0) ? 16'd1 : dwdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            shreg   <= 8'd0;
            div_q   <= DEFAULT_DIV;
            timer   <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shreg <= mem[rd_ptr];
                        div_q <= baud_div;
                        timer <= baud_div - 16'd1;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer == 16'd0) begin
                        timer   <= div_q - 16'd1;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer == 16'd0) begin
                        timer <= div_q - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (timer == 16'd0) state <= ST_IDLE;
                    else timer <= timer - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register access, frame timing, FIFO overflow and reset
// behaviour, checked against a waveform model built from bit slots and byte queues.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_TXD  = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_BAUD = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dwdata = 32'd0;
    logic [3:0]  dwe = 4'd0;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        tx_idle;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    mmio_uart_tx dut (
        .clk     (clk),
        .reset   (reset),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .dwe     (dwe),
        .rdata   (rdata),
        .hit     (hit),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    // Line level j cycles after the pop edge of a single frame (j=0 is the pop edge).
    function automatic logic frame_bit(input logic [7:0] b, input int d, input int j);
        int slot;
        slot = j / d;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Line level t cycles after the first pop for the bytes in exp_q sent back to back.
    function automatic logic stream_bit(input int d, input int t);
        int per, i, r;
        per = 10 * d + 1;
        i = t / per;
        r = t % per;
        if (i >= exp_q.size()) return 1'b1;
        if (r >= 10 * d) return 1'b1;
        return frame_bit(exp_q[i], d, r);
    endfunction

    function automatic logic [31:0] status_model(input int full, input int empty,
                                                 input int busy, input int ovf, input int cnt);
        return 32'(full + 2 * empty + 4 * busy + 8 * ovf + 16 * cnt);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        daddr  = 32'd0;
        dwdata = 32'd0;
        dwe    = 4'd0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
        daddr  = a;
        dwdata = d;
        dwe    = 4'hF;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        drive_write(a, d);
        cycle();
        drive_idle();
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic h);
        daddr = a;
        dwe   = 4'd0;
        #1;
        d = rdata;
        h = hit;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic h;
        drive_idle();
        reset = 1'b0;
        cycle();
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        reset = 1'b1;
        cycle();
        checks++;
        if (tx_idle !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle); end
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== status_model(0, 1, 0, 0, 0) || h !== 1'b1) begin
            errors++; $display("FAIL reset_status: got %h hit=%b want %h hit=1", v, h, status_model(0, 1, 0, 0, 0));
        end
        read_reg(A_BAUD, v, h);
        checks++;
        if (v !== 32'd868) begin errors++; $display("FAIL reset_baud: got %0d want 868", v); end
    endtask

    task automatic test_basic_frame();
        logic e;
        do_reset();
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXD, 32'h55);
        checks++;
        if (tx !== 1'b1 || tx_idle !== 1'b0) begin
            errors++; $display("FAIL basic_write_edge: tx=%b tx_idle=%b want tx=1 tx_idle=0", tx, tx_idle);
        end
        for (int j = 0; j <= 40; j++) begin
            cycle();
            e = (j < 40) ? frame_bit(8'h55, 4, j) : 1'b1;
            checks++;
            if (tx !== e) begin errors++; $display("FAIL basic_tx: j=%0d got %b want %b", j, tx, e); end
            checks++;
            if (tx_idle !== (j >= 40)) begin
                errors++; $display("FAIL basic_tx_idle: j=%0d got %b want %b", j, tx_idle, (j >= 40));
            end
        end
    endtask

    task automatic test_back_to_back();
        int d, n;
        logic e;
        do_reset();
        d = 2;
        exp_q = {8'hA1, 8'h3C};
        n = exp_q.size();
        bus_write(A_BAUD, 32'(d));
        bus_write(A_TXD, 32'(exp_q[0]));
        for (int t = 0; t < n * (10 * d + 1) + 2; t++) begin
            if (t < n - 1) drive_write(A_TXD, 32'(exp_q[t+1])); else drive_idle();
            cycle();
            e = stream_bit(d, t);
            checks++;
            if (tx !== e) begin errors++; $display("FAIL b2b_tx: t=%0d got %b want %b", t, tx, e); end
        end
        checks++;
        if (tx_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_end: got %b want 1", tx_idle); end
    endtask

    task automatic test_overflow();
        logic [31:0] v, w;
        logic h;
        int cnt;
        do_reset();
        bus_write(A_BAUD, 32'hFFFF);
        for (int k = 1; k <= 10; k++) begin
            bus_write(A_TXD, 32'(k));
            // first byte moves into the serialiser on the second write edge
            cnt = (k == 1) ? 1 : ((k - 1 > 8) ? 8 : k - 1);
            w = status_model((cnt == 8), 0, (k >= 2), (k == 10), cnt);
            read_reg(A_STAT, v, h);
            checks++;
            if (v !== w) begin errors++; $display("FAIL ovf_status: write %0d got %h want %h", k, v, w); end
        end
        bus_write(A_STAT, 32'h0);
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== status_model(1, 0, 1, 1, 8)) begin
            errors++; $display("FAIL ovf_noclear: got %h want %h", v, status_model(1, 0, 1, 1, 8));
        end
        bus_write(A_STAT, 32'h8);
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== status_model(1, 0, 1, 0, 8)) begin
            errors++; $display("FAIL ovf_clear: got %h want %h", v, status_model(1, 0, 1, 0, 8));
        end
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL ovf_frozen_start: tx=%b want 0", tx); end
    endtask

    task automatic test_drop();
        logic [7:0] bytes[10];
        logic [31:0] v;
        logic h;
        logic e;
        int d;
        do_reset();
        d = 3;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
        // one byte in the serialiser plus eight queued; the tenth is dropped
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(bytes[i]);
        bus_write(A_BAUD, 32'(d));
        bus_write(A_TXD, 32'(bytes[0]));
        for (int t = 0; t < 9 * (10 * d + 1) + 3; t++) begin
            if (t < 9) drive_write(A_TXD, 32'(bytes[t+1])); else drive_idle();
            cycle();
            e = stream_bit(d, t);
            checks++;
            if (tx !== e) begin errors++; $display("FAIL drop_tx: t=%0d got %b want %b", t, tx, e); end
        end
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== status_model(0, 1, 0, 1, 0)) begin
            errors++; $display("FAIL drop_status: got %h want %h", v, status_model(0, 1, 0, 1, 0));
        end
        bus_write(A_STAT, 32'h8);
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== status_model(0, 1, 0, 0, 0)) begin
            errors++; $display("FAIL drop_clear: got %h want %h", v, status_model(0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_baud_midframe();
        logic [31:0] v;
        logic h;
        logic e;
        do_reset();
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXD, 32'hFF);
        for (int t = 0; t < 64; t++) begin
            if (t == 0) drive_write(A_TXD, 32'h0F);
            else if (t == 9) drive_write(A_BAUD, 32'd2);
            else drive_idle();
            cycle();
            if (t < 40) e = frame_bit(8'hFF, 4, t);
            else if (t == 40) e = 1'b1;
            else if (t < 61) e = frame_bit(8'h0F, 2, t - 41);
            else e = 1'b1;
            checks++;
            if (tx !== e) begin errors++; $display("FAIL baud_mid_tx: t=%0d got %b want %b", t, tx, e); end
        end
        read_reg(A_BAUD, v, h);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL baud_mid_reg: got %0d want 2", v); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        logic h;
        do_reset();
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXD, 32'h00);
        repeat (18) cycle();
        checks++;
        if (tx !== frame_bit(8'h00, 4, 17)) begin
            errors++; $display("FAIL rst_mid_before: got %b want %b", tx, frame_bit(8'h00, 4, 17));
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_async_tx: got %b want 1", tx); end
        cycle();
        reset = 1'b1;
        cycle();
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL rst_mid_status: got %h want 2", v); end
        read_reg(A_BAUD, v, h);
        checks++;
        if (v !== 32'd868) begin errors++; $display("FAIL rst_mid_baud: got %0d want 868", v); end
        drive_idle();
        repeat (5) cycle();
        checks++;
        if (tx !== 1'b1 || tx_idle !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: tx=%b tx_idle=%b want 1 1", tx, tx_idle);
        end
    endtask

    task automatic test_readback();
        logic [31:0] v;
        logic h;
        logic [31:0] st;
        do_reset();
        bus_write(A_BAUD, 32'hFFFF);
        for (int k = 0; k < 3; k++) bus_write(A_TXD, 32'(8'h30 + k));
        st = status_model(0, 0, 1, 0, 2);
        for (int k = 0; k < 3; k++) begin
            read_reg(A_STAT, v, h);
            cycle();
        end
        checks++;
        if (v !== st || h !== 1'b1) begin errors++; $display("FAIL rb_status: got %h hit=%b want %h hit=1", v, h, st); end
        read_reg(A_BAUD, v, h);
        checks++;
        if (v !== 32'hFFFF || h !== 1'b1) begin errors++; $display("FAIL rb_baud: got %h hit=%b want ffff hit=1", v, h); end
        read_reg(A_TXD, v, h);
        checks++;
        if (v !== 32'd0 || h !== 1'b1) begin errors++; $display("FAIL rb_txdata: got %h hit=%b want 0 hit=1", v, h); end
        read_reg(BASE + 32'd12, v, h);
        checks++;
        if (v !== 32'd0 || h !== 1'b0) begin errors++; $display("FAIL rb_plus12: got %h hit=%b want 0 hit=0", v, h); end
        read_reg(BASE + 32'd6, v, h);
        checks++;
        if (v !== 32'd0 || h !== 1'b0) begin errors++; $display("FAIL rb_misaligned: got %h hit=%b want 0 hit=0", v, h); end
        read_reg(BASE - 32'd4, v, h);
        checks++;
        if (v !== 32'd0 || h !== 1'b0) begin errors++; $display("FAIL rb_below: got %h hit=%b want 0 hit=0", v, h); end
        bus_write(BASE + 32'd12, 32'h77);
        daddr = A_TXD; dwdata = 32'h99; dwe = 4'b1110;
        cycle();
        drive_idle();
        read_reg(A_STAT, v, h);
        checks++;
        if (v !== st) begin errors++; $display("FAIL rb_unchanged: got %h want %h", v, st); end
        bus_write(A_BAUD, 32'h0);
        read_reg(A_BAUD, v, h);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL rb_baud_zero: got %0d want 1", v); end
    endtask

    task automatic test_random();
        int d, n;
        logic e;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            d = $urandom_range(1, 3);
            n = $urandom_range(2, 6);
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
            bus_write(A_BAUD, 32'(d));
            bus_write(A_TXD, 32'(exp_q[0]));
            for (int t = 0; t < n * (10 * d + 1) + 2; t++) begin
                if (t < n - 1) drive_write(A_TXD, 32'(exp_q[t+1])); else drive_idle();
                cycle();
                e = stream_bit(d, t);
                checks++;
                if (tx !== e) begin
                    errors++; $display("FAIL rand_tx: run=%0d div=%0d t=%0d got %b want %b", r, d, t, tx, e);
                end
            end
            checks++;
            if (tx_idle !== 1'b1) begin errors++; $display("FAIL rand_idle_end: run=%0d got %b want 1", r, tx_idle); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_overflow();
        test_drop();
        test_baud_midframe();
        test_reset_midframe();
        test_readback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
